// File: rtl/hcms_pkg.sv
// Shared constants for the HCMS-29xx display sequencer: FSM states, control-word layout, font addressing.
// Build option HCMS_BLINK_EN widens stored characters to 8 bits (bit 7 = blink attribute).
package hcms_pkg;

  localparam int COLS_PER_CHAR  = 5;
  localparam int FONT_ADDR_W    = 10;

`ifdef HCMS_BLINK_EN
  localparam int CHAR_W         = 8;
`else
  localparam int CHAR_W         = 7;
`endif

  // Control register byte layout: bit 7 clear selects control word 0.
  localparam int CW_SEL_BIT     = 7;
  localparam int CW0_NORMAL_BIT = 6;
  localparam int CW0_BRIGHT_LSB = 0;
  localparam int CW0_BRIGHT_W   = 4;

  typedef logic [2:0] state_t;
  localparam state_t ST_RST_PULSE = 3'd0;
  localparam state_t ST_RST_REL   = 3'd1;
  localparam state_t ST_CW0       = 3'd2;
  localparam state_t ST_CW1       = 3'd3;
  localparam state_t ST_IDLE      = 3'd4;
  localparam state_t ST_FETCH     = 3'd5;
  localparam state_t ST_LATCH     = 3'd6;
  localparam state_t ST_SEND      = 3'd7;

  function automatic logic [7:0] cw0_byte(input logic [CW0_BRIGHT_W-1:0] bright);
    logic [7:0] w;
    w = '0;
    w[CW_SEL_BIT] = 1'b0;
    w[CW0_NORMAL_BIT] = 1'b1;
    w[CW0_BRIGHT_LSB +: CW0_BRIGHT_W] = bright;
    return w;
  endfunction

endpackage

// File: rtl/hcms_refresh_timer.sv
// Idle-time counter that flags when a forced display refresh is due.
module hcms_refresh_timer #(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (tick_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/hcms_display_ctrl.sv
// HCMS-29xx sequencer: reset pulse, control words, then font-ROM driven refresh frames over a valid/ready byte link.
// Define HCMS_BLINK_EN to enable the blink attribute (bit 7 of each stored character).
module hcms_display_ctrl
  import hcms_pkg::*;
#(
  parameter int         NUM_CHARS      = 4,
  parameter int         RESET_CYCLES   = 16,
  parameter int         REFRESH_CYCLES = 100000,
  parameter logic [7:0] CTRL_WORD1     = 8'h81,
  parameter logic [3:0] INIT_BRIGHT    = 4'hF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_CHARS)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]            wr_char,
  input  logic                         bright_wr,
  input  logic [3:0]                   bright_val,
  output logic [FONT_ADDR_W-1:0]       font_addr,
  input  logic [6:0]                   font_data,
  output logic [7:0]                   tx_data,
  output logic                         tx_cmd,
  output logic                         tx_last,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         disp_reset,
  output logic                         init_done,
  output logic                         frame_done
);

  localparam int AW   = $clog2(NUM_CHARS);
  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [2:0]      COL_LAST = 3'(COLS_PER_CHAR - 1);
  localparam logic [AW-1:0]   CH_TOP   = AW'(NUM_CHARS - 1);

  state_t            state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [AW-1:0]     ch_q, ch_d;
  logic [2:0]        col_q, col_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_cmd_q, tx_cmd_d;
  logic              tx_last_q, tx_last_d;
  logic              tx_valid_q, tx_valid_d;
  logic              disp_reset_q, disp_reset_d;
  logic              init_done_q, init_done_d;
  logic              frame_done_q, frame_done_d;
  logic [3:0]        bright_q, bright_d;
  logic              pend_q, pend_d;
  logic              dirty_q, dirty_d;
  logic              tmr_clr, tmr_tick, tmr_expired;
  logic [CHAR_W-1:0] buf_q [NUM_CHARS];

`ifdef HCMS_BLINK_EN
  logic [4:0] frame_cnt_q;
  logic       phase_q;
  logic       phase_toggle;
  assign phase_toggle = frame_done_d && (frame_cnt_q == 5'd31);
`endif

  hcms_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmr_clr),
    .tick_i   (tmr_tick),
    .expired_o(tmr_expired)
  );

  // Font ROM is addressed straight from the current character/column; it is sampled during FETCH.
  assign font_addr = {buf_q[ch_q][6:0], col_q};

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    ch_d         = ch_q;
    col_d        = col_q;
    tx_data_d    = tx_data_q;
    tx_cmd_d     = tx_cmd_q;
    tx_last_d    = tx_last_q;
    tx_valid_d   = tx_valid_q;
    disp_reset_d = disp_reset_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    tmr_clr      = 1'b0;
    tmr_tick     = 1'b0;
    pend_d       = pend_q;
    dirty_d      = dirty_q;

    case (state_q)
      ST_RST_PULSE: begin
        if (rst_cnt_q == RC_LAST) begin
          disp_reset_d = 1'b0;
          state_d      = ST_RST_REL;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_RST_REL: state_d = ST_CW0;
      ST_CW0: begin
        if (!tx_valid_q) begin
          tx_data_d  = cw0_byte(bright_q);
          tx_cmd_d   = 1'b1;
          tx_last_d  = 1'b0;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = init_done_q ? ST_IDLE : ST_CW1;
        end
      end
      ST_CW1: begin
        if (!tx_valid_q) begin
          tx_data_d  = CTRL_WORD1;
          tx_cmd_d   = 1'b1;
          tx_last_d  = 1'b0;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d  = 1'b0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = ST_CW0;
        end else if (dirty_q || tmr_expired) begin
          dirty_d = 1'b0;
          tmr_clr = 1'b1;
          state_d = ST_FETCH;
        end else begin
          tmr_tick = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        tx_data_d = {1'b0, font_data};
`ifdef HCMS_BLINK_EN
        if (phase_q && buf_q[ch_q][7])
          tx_data_d = 8'h00;
`endif
        tx_cmd_d   = 1'b0;
        tx_last_d  = (ch_q == '0) && (col_q == COL_LAST);
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_FETCH;
          if (col_q != COL_LAST) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (ch_q != '0) begin
              ch_d = ch_q - 1'b1;
            end else begin
              ch_d         = CH_TOP;
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_RST_PULSE;
    endcase

    // Late writes and new brightness requests override the clears above.
    if (wr_en)
      dirty_d = 1'b1;
    if (bright_wr)
      pend_d = 1'b1;
`ifdef HCMS_BLINK_EN
    if (phase_toggle)
      dirty_d = 1'b1;
`endif
  end

  assign bright_d = bright_wr ? bright_val : bright_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RST_PULSE;
      rst_cnt_q    <= '0;
      ch_q         <= CH_TOP;
      col_q        <= '0;
      tx_data_q    <= '0;
      tx_cmd_q     <= 1'b0;
      tx_last_q    <= 1'b0;
      tx_valid_q   <= 1'b0;
      disp_reset_q <= 1'b1;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      bright_q     <= INIT_BRIGHT;
      pend_q       <= 1'b0;
      dirty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      ch_q         <= ch_d;
      col_q        <= col_d;
      tx_data_q    <= tx_data_d;
      tx_cmd_q     <= tx_cmd_d;
      tx_last_q    <= tx_last_d;
      tx_valid_q   <= tx_valid_d;
      disp_reset_q <= disp_reset_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      bright_q     <= bright_d;
      pend_q       <= pend_d;
      dirty_q      <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++)
        buf_q[i] <= '0;
    end else if (wr_en) begin
      buf_q[wr_addr] <= wr_char;
    end
  end

`ifdef HCMS_BLINK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (frame_done_d) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
      if (phase_toggle)
        phase_q <= ~phase_q;
    end
  end
`endif

  assign tx_data    = tx_data_q;
  assign tx_cmd     = tx_cmd_q;
  assign tx_last    = tx_last_q;
  assign tx_valid   = tx_valid_q;
  assign disp_reset = disp_reset_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hcms_display_ctrl.sv
// Self-checking bench for hcms_display_ctrl: transaction-level byte scoreboard plus directed scenarios.
module tb_hcms_display_ctrl;
  import hcms_pkg::*;

  localparam int NC = 4;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [CHAR_W-1:0] wr_char = '0;
  logic              bright_wr = 1'b0;
  logic [3:0]        bright_val = '0;
  logic [9:0]        font_addr;
  logic [6:0]        font_data = '0;
  logic [7:0]        tx_data;
  logic              tx_cmd, tx_last, tx_valid;
  logic              tx_ready = 1'b1;
  logic              disp_reset, init_done, frame_done;

  hcms_display_ctrl #(
    .NUM_CHARS(NC), .RESET_CYCLES(16), .REFRESH_CYCLES(100000),
    .CTRL_WORD1(8'h81), .INIT_BRIGHT(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .bright_wr(bright_wr), .bright_val(bright_val), .font_addr(font_addr), .font_data(font_data),
    .tx_data(tx_data), .tx_cmd(tx_cmd), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .disp_reset(disp_reset), .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Font ROM stand-in: registered, returns the low address bits.
  always @(posedge clk) font_data <= font_addr[6:0];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nb = 0;
  int n_fd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs and handshake as seen by the DUT at each rising edge.
  logic              p_rst, p_valid, p_ready, p_cmd, p_last, p_wr, p_bw;
  logic [7:0]        p_data;
  logic [AW-1:0]     p_addr;
  logic [CHAR_W-1:0] p_char;
  logic [3:0]        p_bval;
  always @(posedge clk) begin
    p_rst <= reset; p_valid <= tx_valid; p_ready <= tx_ready; p_data <= tx_data;
    p_cmd <= tx_cmd; p_last <= tx_last; p_wr <= wr_en; p_addr <= wr_addr;
    p_char <= wr_char; p_bw <= bright_wr; p_bval <= bright_val;
  end

  // Behavioural model: which messages the display must receive, in order.
  typedef struct packed { logic [7:0] d; logic c; logic l; logic i; } exp_t;
  exp_t        exp_q[$];
  logic [6:0]  m_buf [NC];
  logic [3:0]  m_bright;
  bit          m_pend, m_dirty, m_init;
  logic [7:0]  log_d [256];
  logic        log_c [256];
  logic        log_l [256];
  int          log_t [256];

  function automatic void push(input logic [7:0] d, input logic c, input logic l, input logic i);
    exp_t e;
    e.d = d; e.c = c; e.l = l; e.i = i;
    exp_q.push_back(e);
  endfunction

  function automatic void plan_next();
    int v;
    if (!m_init) begin
      push(8'h40 | {4'h0, m_bright}, 1'b1, 1'b0, 1'b0);
      push(8'h81, 1'b1, 1'b0, 1'b1);
    end else if (m_pend) begin
      m_pend = 0;
      push(8'h40 | {4'h0, m_bright}, 1'b1, 1'b0, 1'b0);
    end else if (m_dirty) begin
      m_dirty = 0;
      for (int ch = NC - 1; ch >= 0; ch--)
        for (int col = 0; col < 5; col++) begin
          v = (int'(m_buf[ch]) * 8 + col) % 128;
          push(8'(v), 1'b0, (ch == 0 && col == 4), 1'b0);
        end
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   fd_exp;
    cyc++;
    fd_exp = 0;
    if (p_rst) begin
      for (int k = 0; k < NC; k++) m_buf[k] = '0;
      m_bright = 4'hF; m_pend = 0; m_dirty = 1; m_init = 0; nb = 0;
      exp_q.delete();
      chk("rst_outputs", {disp_reset, tx_valid, tx_cmd, tx_last, init_done, frame_done},
          {1'b1, 5'b0});
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_font_addr", font_addr, 10'h000);
    end else begin
      if (p_valid && p_ready) begin
        if (exp_q.size() == 0) plan_next();
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {p_data, p_cmd, p_last}, {e.d, e.c, e.l});
          if (e.l) fd_exp = 1;
          if (e.i) m_init = 1;
        end
        if (nb < 256) begin
          log_d[nb] = p_data; log_c[nb] = p_cmd; log_l[nb] = p_last; log_t[nb] = cyc;
        end
        nb++;
        chk("valid_drop", tx_valid, 1'b0);
      end else if (p_valid) begin
        chk("hold_stable", {tx_valid, tx_data, tx_cmd, tx_last}, {1'b1, p_data, p_cmd, p_last});
      end
      chk("frame_done", frame_done, fd_exp);
      chk("init_done", init_done, m_init);
      if (fd_exp) n_fd++;
      if (p_wr) begin
        m_buf[p_addr] = p_char[6:0];
        m_dirty = 1;
      end
      if (p_bw) begin
        m_bright = p_bval;
        m_pend = 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_nb(input int target, input int budget, input string name);
    int k = 0;
    while (nb < target && k < budget) begin
      step();
      k++;
    end
    chk(name, (nb >= target), 1'b1);
  endtask

  task automatic write_char(input int a, input int c);
    wr_en = 1'b1; wr_addr = AW'(a); wr_char = CHAR_W'(c);
    step();
    wr_en = 1'b0;
  endtask

  // Counts cycles of disp_reset high after release; optionally loads 'A'..'D' meanwhile.
  task automatic reset_pulse(input bit load_abcd);
    int n = 0;
    while (disp_reset === 1'b1 && n < 100) begin
      if (load_abcd && n < NC) begin
        wr_en = 1'b1; wr_addr = AW'(n); wr_char = CHAR_W'(8'h41 + n);
      end else begin
        wr_en = 1'b0;
      end
      step();
      n++;
    end
    wr_en = 1'b0;
    chk("disp_reset_high_cycles", n, 16);
  endtask

  initial begin
    reset = 1'b1;
    repeat (4) step();
    reset = 1'b0;
    reset_pulse(1'b1);

    // Init words, then the ABCD frame with byte 3 stalled for 7 clocks.
    wait_nb(4, 300, "wait_init_and_two_bytes");
    tx_ready = 1'b0;
    repeat (7) step();
    tx_ready = 1'b1;
    wait_nb(22, 500, "wait_frame1");
    chk("cw0_init", {log_d[0], log_c[0]}, {8'h4F, 1'b1});
    chk("cw1_init", {log_d[1], log_c[1]}, {8'h81, 1'b1});
    chk("disp_reset_low", disp_reset, 1'b0);
    chk("f1_D_col0", {log_d[2], log_c[2], log_l[2]}, {8'h20, 1'b0, 1'b0});
    chk("f1_D_col4", log_d[6], 8'h24);
    chk("f1_C_col0", log_d[7], 8'h18);
    chk("f1_A_col4_last", {log_d[21], log_l[21], log_l[20]}, {8'h0C, 1'b1, 1'b0});
    chk("f1_frame_done_count", n_fd, 1);

    // Write at frame byte 10 forces a second frame straight after.
    repeat (5) step();
    write_char(3, 8'h45);
    wait_nb(32, 500, "wait_frame2_byte10");
    write_char(3, 8'h46);
    wait_nb(62, 500, "wait_frame3");
    chk("f2_E_col0", log_d[22], 8'h28);
    chk("f3_F_col0", log_d[42], 8'h30);
    chk("f3_back_to_back", (log_t[42] - log_t[41] <= 6), 1'b1);
    chk("f3_frame_done_count", n_fd, 3);

    // Brightness change mid-frame: frame finishes, then CW0, then nothing.
    repeat (5) step();
    write_char(0, 8'h47);
    wait_nb(67, 500, "wait_frame4_mid");
    bright_val = 4'h3; bright_wr = 1'b1;
    step();
    bright_wr = 1'b0;
    wait_nb(83, 500, "wait_bright_cw0");
    chk("f4_G_col4_last", {log_d[81], log_l[81]}, {8'h3C, 1'b1});
    chk("bright_cw0", {log_d[82], log_c[82]}, {8'h43, 1'b1});
    repeat (300) step();
    chk("no_extra_frame", nb, 83);
    chk("init_done_after_bright", init_done, 1'b1);

    // Reset in the middle of a frame.
    write_char(1, 8'h48);
    wait_nb(88, 500, "wait_frame5_mid");
    reset = 1'b1;
    step();
    chk("reset_abort_valid", tx_valid, 1'b0);
    step();
    reset = 1'b0;
    reset_pulse(1'b0);
    wait_nb(22, 500, "wait_reinit_frame");
    chk("reinit_cw0", {log_d[0], log_c[0]}, {8'h4F, 1'b1});
    chk("reinit_cw1", {log_d[1], log_c[1]}, {8'h81, 1'b1});
    chk("reinit_blank_col0", log_d[2], 8'h00);
    chk("reinit_blank_last", {log_d[21], log_l[21]}, {8'h04, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/hcms_display_ctrl.md
Name: hcms_display_ctrl

Overview:
- Sequencer for an HCMS-29xx dot-matrix display; drives the existing byte-serial transmitter through a valid/ready byte interface.
- Performs the power-up sequence: display reset pulse, then control words 0 and 1.
- Refreshes the display from an internal character buffer through an external 5x7 font ROM.
- Services brightness changes at frame boundaries.

Parameters:
- NUM_CHARS, 4, display characters; power of two, 2..16.
- RESET_CYCLES, 16, clk cycles disp_reset stays high.
- REFRESH_CYCLES, 100000, idle cycles before a forced refresh frame.
- CTRL_WORD1, 8'h81, control word 1 sent at init.
- INIT_BRIGHT, 4'hF, initial brightness value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  character buffer write strobe
- wr_addr  in  $clog2(NUM_CHARS)  buffer index
- wr_char  in  7  character code
- bright_wr  in  1  brightness update request
- bright_val  in  4  new brightness value
- font_addr  out  10  {char_code[6:0], col[2:0]}
- font_data  in  7  column dots, valid 1 clk after font_addr
- tx_data  out  8  byte to transmitter
- tx_cmd  out  1  1 = control register, 0 = dot register
- tx_last  out  1  high with the final byte of a dot frame
- tx_valid  out  1  byte offered
- tx_ready  in  1  transmitter can accept
- disp_reset  out  1  display reset, active-high
- init_done  out  1  init sequence complete
- frame_done  out  1  1-clk pulse after the last frame byte is accepted

Behaviour:
- Reset values: disp_reset=1, tx_valid=0, tx_cmd=0, tx_last=0, tx_data=0, font_addr=0, init_done=0, frame_done=0.
- Reset state: buffer cleared to 0, brightness=INIT_BRIGHT, dirty=1, bright_pend=0, refresh counter=0, state=RST_PULSE.
- Reset mid-operation aborts any transfer immediately and restarts from RST_PULSE.
- Handshake: byte transfers on a cycle with tx_valid&&tx_ready.
  - tx_data, tx_cmd and tx_last stay stable while tx_valid=1 and !tx_ready.
  - tx_valid drops the cycle after acceptance.
  - No combinational path from tx_ready to tx_valid.
- States:
  - RST_PULSE: disp_reset=1 for RESET_CYCLES clks.
  - RST_REL: disp_reset=0 for 1 clk.
  - CW0: send {1'b0, 1'b1 (normal mode), 2'b00, brightness}, tx_cmd=1.
  - CW1: send CTRL_WORD1, tx_cmd=1. After acceptance, init_done=1 (sticky until reset).
  - IDLE:
    - bright_pend has priority and goes to CW0; init_done stays 1.
    - else if dirty or refresh counter==REFRESH_CYCLES-1: clear dirty, clear counter, go to FETCH.
    - else increment the refresh counter.
  - FETCH: drive font_addr={buf[ch], col}.
  - LATCH: capture font_data into tx_data={1'b0, font_data}, tx_cmd=0, tx_valid=1.
  - SEND: wait for acceptance, then advance col/ch and return to FETCH, or go to IDLE after the last byte and pulse frame_done.
- Byte order: ch from NUM_CHARS-1 down to 0; col 0..4 within each character; 5*NUM_CHARS bytes per frame.
- tx_last=1 only on the byte with ch=0, col=4.
- Buffer writes take effect immediately and set dirty. A write landing during a frame keeps dirty=1, so another frame follows.
- Simultaneous wr_en and IDLE frame start: write is applied and dirty remains 1.
- bright_wr latches bright_val and sets bright_pend.
  - Latest value wins if several arrive before service.
  - During init or a frame, the update is serviced at the next IDLE.
  - After CW0 for a brightness update: return to IDLE with no frame forced.
- col counter wraps 4->0; ch counter wraps 0->NUM_CHARS-1 only at frame end.

Optional Feature:
- HCMS_BLINK_EN defined:
  - Buffer width is 8; wr_char widens to 8, and bit 7 is the blink attribute.
  - A blink phase flag toggles every 32 frames.
  - While the phase flag =1, columns of blink-marked characters are sent as 8'h00.
  - Each phase toggle sets dirty.
- HCMS_BLINK_EN undefined: 7-bit buffer, no blink logic, wr_char is 7 bits.

Decomposition:
- Package hcms_pkg holds:
  - state enum
  - control-word bit positions
  - COLS_PER_CHAR=5
  - font address width constant
- Sub-module hcms_refresh_timer: refresh counter with clear/tick.
- Everything else stays in one module.

Test Plan:
- Reset released, tx_ready=1 -> disp_reset high 16 clks; bytes 8'h4F (cmd=1) then 8'h81 (cmd=1); init_done=1.
- Write chars 0..3 = 'A','B','C','D', font model data = addr[6:0] -> 20 bytes in order D c0..c4, C, B, A; tx_last on byte 20 only; frame_done pulse.
- tx_ready low 7 clks during byte 3 -> tx_data/tx_cmd/tx_last held stable; no byte lost or duplicated.
- bright_wr val=4'h3 mid-frame -> frame completes, then 8'h43 cmd=1; no extra frame.
- wr_en at frame byte 10 -> second full frame follows immediately.
- reset asserted mid-frame -> tx_valid=0 next clk; full init sequence repeats.
